mdu_sched: RTL and testbench

MDU_SCHED -- requirements
Module: mdu_sched

---
 rtl/mdu_sched.sv | 173 +++++++++++++++++
 tb/tb_mdu_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched: issue/response sequencer for RISC-V M-extension ops.
// Prepares unsigned operands for an external iterative mul/div unit, handles
// divide-by-zero and signed-overflow results locally, applies the sign
// fix-up to the unit result and holds the response until it is taken.
//
// Handshakes:
//   request  : req_valid is held stable while stall=1; the op is accepted in
//              an IDLE cycle with req_valid=1 and flush=0.
//   response : resp_valid stays high with resp_data stable until a cycle
//              with resp_ready=1 (taken) or flush=1 (discarded).
//   unit     : unit_start pulses for one cycle; unit_a/unit_b stay constant
//              until the unit answers with a one-cycle unit_done.
module mdu_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic        req_word,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  input  logic        resp_ready,
  output logic        stall,
  output logic        unit_start,
  output logic        unit_is_mul,
  output logic [63:0] unit_a,
  output logic [63:0] unit_b,
  input  logic        unit_done,
  input  logic [63:0] unit_lo,
  input  logic [63:0] unit_hi,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state;

  // Op context kept while the unit works
  logic word_r;   // *W variant: result is sign-extended from bit 31
  logic lo_sel_r; // result comes from unit_lo (MUL, DIV, DIVU) else unit_hi
  logic neg_r;    // unit result must be negated (signed fix-up)

  // Decoded request and prepared operands
  logic        p_mul, p_div, p_divu, p_rem, p_remu, p_signed, p_sext;
  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic        a_neg, b_neg, b_zero, a_min, ovf, special;
  logic [63:0] spec_res;
  logic [63:0] raw_res, fix_res;

  function automatic logic [63:0] fix_word(input logic [63:0] v, input logic w);
    fix_word = w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // Request decode, operand preparation and special-case detection
  always_comb begin
    p_mul    = (req_op == 3'd0) || (req_op > 3'd4);
    p_div    = (req_op == 3'd1);
    p_divu   = (req_op == 3'd2);
    p_rem    = (req_op == 3'd3);
    p_remu   = (req_op == 3'd4);
    p_signed = p_div | p_rem;
    p_sext   = p_mul | p_signed;

    if (req_word) begin
      a_ext = p_sext ? {{32{req_a[31]}}, req_a[31:0]} : {32'd0, req_a[31:0]};
      b_ext = p_sext ? {{32{req_b[31]}}, req_b[31:0]} : {32'd0, req_b[31:0]};
    end else begin
      a_ext = req_a;
      b_ext = req_b;
    end

    a_neg = p_signed & a_ext[63];
    b_neg = p_signed & b_ext[63];
    a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
    b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;

    b_zero  = (b_ext == 64'd0);
    a_min   = req_word ? (a_ext == 64'hFFFF_FFFF_8000_0000)
                       : (a_ext == 64'h8000_0000_0000_0000);
    ovf     = p_signed & a_min & (b_ext == {64{1'b1}});
    special = ~p_mul & (b_zero | ovf);

    // Divide by zero wins over overflow (b=0 cannot also be -1)
    spec_res = 64'd0;
    if (b_zero) begin
      spec_res = (p_div | p_divu) ? {64{1'b1}} : a_ext;
    end else if (ovf) begin
      spec_res = p_div ? a_ext : 64'd0;
    end
  end

  // Unit result selection and sign fix-up
  always_comb begin
    raw_res = lo_sel_r ? unit_lo : unit_hi;
    fix_res = neg_r ? (~raw_res + 64'd1) : raw_res;
    fix_res = fix_word(fix_res, word_r);
  end

  assign stall     = req_valid & ~resp_valid;
  assign fsm_state = state;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_data   <= 64'd0;
      unit_start  <= 1'b0;
      unit_is_mul <= 1'b0;
      unit_a      <= 64'd0;
      unit_b      <= 64'd0;
      word_r      <= 1'b0;
      lo_sel_r    <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          unit_start <= 1'b0;
          if (req_valid && !flush) begin
            word_r      <= req_word;
            lo_sel_r    <= p_mul | p_div | p_divu;
            neg_r       <= (p_div & (a_neg ^ b_neg)) | (p_rem & a_neg);
            unit_is_mul <= p_mul;
            unit_a      <= p_signed ? a_mag : a_ext;
            unit_b      <= p_signed ? b_mag : b_ext;
            if (special) begin
              resp_data  <= fix_word(spec_res, req_word);
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              unit_start <= 1'b1;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          unit_start <= 1'b0;
          if (flush) begin
            // A unit that finishes in the flush cycle needs no draining
            state <= unit_done ? IDLE : DRAIN;
          end else if (unit_done) begin
            resp_data  <= fix_res;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          unit_start <= 1'b0;
          if (unit_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: vector table plus hand-written corner sequences for mdu_sched,
// with a behavioural iterative unit and a scoreboard of expected responses.
module tb_mdu_sched;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic        req_word;
  logic [63:0] req_a, req_b;
  logic        flush;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_ready;
  logic        stall;
  logic        unit_start, unit_is_mul;
  logic [63:0] unit_a, unit_b;
  logic        unit_done;
  logic [63:0] unit_lo, unit_hi;
  logic [1:0]  fsm_state;

  mdu_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_word(req_word), .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .stall(stall), .unit_start(unit_start), .unit_is_mul(unit_is_mul),
    .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done),
    .unit_lo(unit_lo), .unit_hi(unit_hi), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural unit ----------------
  int          unit_delay = 1;
  logic        auto_done = 1'b0;
  logic [63:0] auto_lo = '0, auto_hi = '0;
  logic        ubusy = 1'b0;
  int          cnt = 0;
  logic        man_done = 1'b0;
  logic        ovr_en = 1'b0;
  logic [63:0] ovr_lo = '0, ovr_hi = '0;

  assign unit_done = auto_done | man_done;
  assign unit_lo   = ovr_en ? ovr_lo : auto_lo;
  assign unit_hi   = ovr_en ? ovr_hi : auto_hi;

  always @(posedge clk) begin
    auto_done <= 1'b0;
    if (reset) begin
      ubusy <= 1'b0;
      cnt   <= 0;
    end else if (unit_start) begin
      auto_lo <= unit_is_mul ? unit_a * unit_b : (unit_b == 64'd0 ? {64{1'b1}} : unit_a / unit_b);
      auto_hi <= (unit_b == 64'd0) ? unit_a : unit_a % unit_b;
      if (unit_delay <= 1) begin
        auto_done <= 1'b1;
        ubusy     <= 1'b0;
      end else begin
        ubusy <= 1'b1;
        cnt   <= unit_delay - 1;
      end
    end else if (ubusy) begin
      if (cnt <= 1) begin
        auto_done <= 1'b1;
        ubusy     <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RISC-V M-extension reference result
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] r32;
    logic [63:0] r;
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      case (op)
        3'd1: if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF;
              else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
              else r32 = sa32 / sb32;
        3'd2: r32 = (b[31:0] == 32'd0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
        3'd3: if (b[31:0] == 32'd0) r32 = a[31:0];
              else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = 32'd0;
              else r32 = sa32 % sb32;
        3'd4: r32 = (b[31:0] == 32'd0) ? a[31:0] : a[31:0] % b[31:0];
        default: r32 = a[31:0] * b[31:0];
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      sa = a;
      sb = b;
      case (op)
        3'd1: if (b == 64'd0) r = {64{1'b1}};
              else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r = a;
              else r = sa / sb;
        3'd2: r = (b == 64'd0) ? {64{1'b1}} : a / b;
        3'd3: if (b == 64'd0) r = a;
              else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r = 64'd0;
              else r = sa % sb;
        3'd4: r = (b == 64'd0) ? a : a % b;
        default: r = a * b;
      endcase
    end
    return r;
  endfunction

  // Expected unit operands and whether the op bypasses the unit
  task automatic exp_unit(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] ua,
                          output logic [63:0] ub, output logic sp);
    logic mulop, sgn, sx;
    logic [63:0] ae, be;
    mulop = (op == 3'd0) || (op > 3'd4);
    sgn   = (op == 3'd1) || (op == 3'd3);
    sx    = mulop || sgn;
    ae = w ? (sx ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    be = w ? (sx ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    ua = (sgn && ae[63]) ? 64'd0 - ae : ae;
    ub = (sgn && be[63]) ? 64'd0 - be : be;
    sp = !mulop && ((be == 64'd0) ||
         (sgn && be == {64{1'b1}} &&
          ae == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fsm_state != 2'd0 && n < 30) begin
      tick();
      n++;
    end
    if (fsm_state != 2'd0) chk("wait_idle_timeout", {62'd0, fsm_state}, 64'd0);
  endtask

  // Drive one op, check issue/latency, take the response through the scoreboard
  task automatic run_op(input string nm, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input int dly,
                        input logic [63:0] exp_d);
    logic [63:0] ua, ub, e;
    logic sp, hold_bad;
    int cyc;
    exp_unit(op, w, a, b, ua, ub, sp);
    unit_delay = dly;
    wait_idle();
    req_valid = 1'b1; req_op = op; req_word = w; req_a = a; req_b = b;
    exp_q.push_back(exp_d);
    tick();
    if (sp) begin
      chk({nm, "_spec_valid"}, {63'd0, resp_valid}, 64'd1);
      chk({nm, "_spec_nostart"}, {63'd0, unit_start}, 64'd0);
    end else begin
      chk({nm, "_start"}, {63'd0, unit_start}, 64'd1);
      chk({nm, "_ismul"}, {63'd0, unit_is_mul}, {63'd0, (op == 3'd0) || (op > 3'd4)});
      chk({nm, "_ua"}, unit_a, ua);
      chk({nm, "_ub"}, unit_b, ub);
      chk({nm, "_stall_busy"}, {63'd0, stall}, 64'd1);
      cyc = 0;
      hold_bad = 1'b0;
      while (!resp_valid && cyc < 60) begin
        tick();
        cyc++;
        if (fsm_state == 2'd1 && (unit_start || unit_a !== ua || unit_b !== ub)) hold_bad = 1'b1;
      end
      chk({nm, "_latency"}, cyc, dly + 1);
      chk({nm, "_hold"}, {63'd0, hold_bad}, 64'd0);
    end
    if (resp_valid) begin
      resp_ready = 1'b1;
      if (exp_q.size() == 0) chk({nm, "_sb_empty"}, 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk({nm, "_data"}, resp_data, e);
      end
      tick();
      chk({nm, "_idle_after"}, {62'd0, fsm_state}, 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    int          dly;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [63:0] d0, ra, rb, e;
    logic [2:0] rop;
    logic rw;
    int n;

    reset = 1'b1; req_valid = 1'b1; req_op = 3'd1; req_word = 1'b0;
    req_a = 64'h1234; req_b = 64'h0; flush = 1'b0; resp_ready = 1'b0;
    tick(); tick();
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_unit_start", {63'd0, unit_start}, 64'd0);
    chk("rst_unit_is_mul", {63'd0, unit_is_mul}, 64'd0);
    chk("rst_unit_a", unit_a, 64'd0);
    chk("rst_unit_b", unit_b, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd1);
    chk("rst_state", {62'd0, fsm_state}, 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    tick();

    vecs[0]  = '{"div_m7_2",    3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[1]  = '{"rem_m7_2",    3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{"divu_b0",     3'd2, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3]  = '{"remu_9_0",    3'd4, 1'b0, 64'd9, 64'd0, 1, 64'd9};
    vecs[4]  = '{"divw_ovf",    3'd1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000};
    vecs[5]  = '{"remw_ovf",    3'd3, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0};
    vecs[6]  = '{"mul_x3",      3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd3, 2, 64'h369D_0369_D036_9CD0};
    vecs[7]  = '{"divu_100_7",  3'd2, 1'b0, 64'd100, 64'd7, 1, 64'd14};
    vecs[8]  = '{"remu_100_7",  3'd4, 1'b0, 64'd100, 64'd7, 3, 64'd2};
    vecs[9]  = '{"div_ovf64",   3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000};
    vecs[10] = '{"rem_ovf64",   3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0};
    vecs[11] = '{"divw_m20_3",  3'd1, 1'b1, 64'hDEAD_BEEF_FFFF_FFEC, 64'h1234_5678_0000_0003, 4, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[12] = '{"remuw",       3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 2, 64'd2};
    vecs[13] = '{"rem_7_m2",    3'd3, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 2, 64'd1};
    vecs[14] = '{"div_7_m2",    3'd1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 2, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[15] = '{"mul_rsvd6",   3'd6, 1'b0, 64'd5, 64'd6, 1, 64'd30};
    vecs[16] = '{"divuw_b0",    3'd2, 1'b1, 64'd77, 64'hFFFF_FFFF_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF};

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].nm, vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].dly, vecs[i].exp);
    end

    // MULW with a forced unit product: only bits 31:0 matter
    ovr_en = 1'b1; ovr_lo = 64'h0000_0001_8000_0000; ovr_hi = 64'd0;
    run_op("mulw_ovr", 3'd0, 1'b1, 64'h1234, 64'h5678, 2, 64'hFFFF_FFFF_8000_0000);
    ovr_en = 1'b0;

    // Flush in the second BUSY cycle; unit finishes three cycles later
    unit_delay = 4;
    wait_idle();
    req_valid = 1'b1; req_op = 3'd2; req_word = 1'b0; req_a = 64'd50; req_b = 64'd5;
    tick();
    chk("fl_start", {63'd0, unit_start}, 64'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_b = 64'd0;
    chk("fl_drain", {62'd0, fsm_state}, 64'd3);
    n = 0;
    d0 = 64'd0;
    while (fsm_state == 2'd3 && n < 10) begin
      if (resp_valid || unit_start) d0 = 64'd1;
      tick();
      n++;
    end
    chk("fl_drain_len", n, 64'd3);
    chk("fl_no_resp", d0, 64'd0);
    chk("fl_idle", {62'd0, fsm_state}, 64'd0);
    chk("fl_idle_norv", {63'd0, resp_valid}, 64'd0);
    tick();
    chk("fl_next_valid", {63'd0, resp_valid}, 64'd1);
    chk("fl_next_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0; resp_ready = 1'b0;

    // unit_done in the start cycle, then backpressure for 4 cycles; the
    // behavioural unit's own late done lands in DONE and must be ignored
    unit_delay = 3;
    ovr_en = 1'b1; ovr_lo = 64'd3; ovr_hi = 64'd1;
    wait_idle();
    req_valid = 1'b1; req_op = 3'd2; req_word = 1'b0; req_a = 64'd10; req_b = 64'd3;
    exp_q.push_back(64'd3);
    tick();
    chk("sc_start", {63'd0, unit_start}, 64'd1);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("sc_valid", {63'd0, resp_valid}, 64'd1);
    d0 = resp_data;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (!resp_valid || resp_data !== d0 || fsm_state != 2'd2 || stall) n++;
      tick();
    end
    chk("bp_stable", n, 64'd0);
    resp_ready = 1'b1;
    e = exp_q.pop_front();
    chk("bp_data", resp_data, e);
    tick();
    chk("bp_exit_idle", {62'd0, fsm_state}, 64'd0);
    req_valid = 1'b0; resp_ready = 1'b0; ovr_en = 1'b0;

    // Flush together with unit_done in BUSY goes straight to IDLE
    unit_delay = 10;
    req_valid = 1'b1; req_op = 3'd2; req_a = 64'd20; req_b = 64'd4;
    tick();
    man_done = 1'b1; flush = 1'b1;
    tick();
    man_done = 1'b0; flush = 1'b0; req_valid = 1'b0;
    chk("fd_idle", {62'd0, fsm_state}, 64'd0);
    chk("fd_norv", {63'd0, resp_valid}, 64'd0);

    // Flush in IDLE blocks acceptance; flush in DONE beats resp_ready
    req_valid = 1'b1; req_op = 3'd2; req_a = 64'd5; req_b = 64'd0; flush = 1'b1;
    tick();
    chk("fi_blocked", {62'd0, fsm_state}, 64'd0);
    flush = 1'b0;
    tick();
    chk("fdn_valid", {63'd0, resp_valid}, 64'd1);
    flush = 1'b1; resp_ready = 1'b1;
    tick();
    flush = 1'b0; resp_ready = 1'b0; req_valid = 1'b0;
    chk("fdn_idle", {62'd0, fsm_state}, 64'd0);
    chk("fdn_norv", {63'd0, resp_valid}, 64'd0);

    // Reset mid-BUSY, then a stray unit_done
    unit_delay = 4;
    req_valid = 1'b1; req_op = 3'd0; req_a = 64'd1000; req_b = 64'd3;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rb_state", {62'd0, fsm_state}, 64'd0);
    chk("rb_outs", {resp_valid, unit_start, unit_is_mul} | resp_data | unit_a | unit_b, 64'd0);
    chk("rb_stall", {63'd0, stall}, 64'd1);
    reset = 1'b0; req_valid = 1'b0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    chk("rb_stray_done", {61'd0, resp_valid, fsm_state}, 64'd0);

    // Random ops against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      rb  = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom_range(0, 1) ? 0 : $urandom), $urandom};
      run_op($sformatf("rnd%0d", i), rop, rw, ra, rb, $urandom_range(1, 6), ref_result(rop, rw, ra, rb));
    end

    chk("sb_drained", exp_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
